// File: rtl/avmm_cfg_pkg.sv
// Shared types and helpers for the Avalon-MM configuration responder.
package avmm_cfg_pkg;

   localparam int unsigned AVMM_ADDR_W = 17;
   localparam int unsigned AVMM_DATA_W = 32;
   localparam int unsigned AVMM_BE_W   = 4;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_ACK
   } rsp_state_t;

   function automatic logic [AVMM_DATA_W-1:0] be_merge(
      input logic [AVMM_DATA_W-1:0] old_v,
      input logic [AVMM_DATA_W-1:0] new_v,
      input logic [AVMM_BE_W-1:0]   be
   );
      logic [AVMM_DATA_W-1:0] merged;
      merged = old_v;
      for (int unsigned b = 0; b < AVMM_BE_W; b++) begin
         if (be[b]) merged[8*b +: 8] = new_v[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/avmm_cfg_regfile.sv
// Register storage with byte-enable merge on write and an indexed read mux.
module avmm_cfg_regfile
   import avmm_cfg_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_we,
   input  logic [IDX_W-1:0]                i_widx,
   input  logic [AVMM_DATA_W-1:0]          i_wdata,
   input  logic [AVMM_BE_W-1:0]            i_be,
   input  logic [IDX_W-1:0]                i_ridx,
   output logic [AVMM_DATA_W-1:0]          o_rdata,
   output logic [AVMM_DATA_W*NUM_REGS-1:0] o_regs
);

   logic [AVMM_DATA_W-1:0] r_regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_widx] <= be_merge(r_regs[i_widx], i_wdata, i_be);
      end
   end

   assign o_rdata = r_regs[i_ridx];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_regs[AVMM_DATA_W*g +: AVMM_DATA_W] = r_regs[g];
   end

endmodule

// File: rtl/avmm_cfg_responder.sv
// Avalon-MM register-file responder: waitrequest stretching, address decode,
// error tracking and registered read/write-strobe outputs.
module avmm_cfg_responder
   import avmm_cfg_pkg::*;
#(
   parameter logic [AVMM_ADDR_W-1:0] BASE_ADDR   = 17'h00200,
   parameter int unsigned            NUM_REGS    = 32,
   parameter int unsigned            WAIT_CYCLES = 2,
   parameter logic [AVMM_DATA_W-1:0] BAD_RDATA   = 32'hDEAD_BEEF,
   localparam int unsigned           IDX_W       = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [AVMM_ADDR_W-1:0]          avmm_address,
   input  logic [AVMM_DATA_W-1:0]          avmm_writedata,
   input  logic [AVMM_BE_W-1:0]            avmm_byteenable,
   input  logic                            avmm_write,
   input  logic                            avmm_read,
   output logic                            avmm_waitrequest,
   output logic [AVMM_DATA_W-1:0]          avmm_readdata,
   output logic                            avmm_readdatavalid,
   output logic [AVMM_DATA_W*NUM_REGS-1:0] cfg_regs,
   output logic                            wr_strobe,
   output logic [IDX_W-1:0]                wr_index,
   input  logic                            clr_err,
   output logic                            err_sticky
);

   localparam logic [AVMM_ADDR_W:0] ADDR_LO  = {1'b0, BASE_ADDR};
   localparam logic [AVMM_ADDR_W:0] ADDR_HI  = ADDR_LO + (AVMM_ADDR_W+1)'(4*NUM_REGS);
   localparam logic [3:0]           CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   rsp_state_t             r_state;
   logic [3:0]             r_cnt;
   logic [AVMM_DATA_W-1:0] r_readdata;
   logic                   r_readdatavalid;
   logic                   r_wr_strobe;
   logic [IDX_W-1:0]       r_wr_index;
   logic                   r_err_sticky;

   logic                   w_cmd;
   logic                   w_in_range;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_err;
   logic                   w_we;
   logic [AVMM_DATA_W-1:0] w_rd;

   assign w_cmd      = avmm_write | avmm_read;
   assign w_in_range = ({1'b0, avmm_address} >= ADDR_LO) &&
                       ({1'b0, avmm_address} <  ADDR_HI) &&
                       (avmm_address[1:0] == 2'b00);
   assign w_idx      = IDX_W'((avmm_address - BASE_ADDR) >> 2);
   // Write+read together is a protocol error; any out-of-range command is a range error.
   assign w_err      = (avmm_write && avmm_read) || (w_cmd && !w_in_range);
   assign w_we       = (r_state == RSP_ACK) && avmm_write && w_in_range;

   assign avmm_waitrequest = w_cmd && (r_state != RSP_ACK);

   avmm_cfg_regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_widx  (w_idx),
      .i_wdata (avmm_writedata),
      .i_be    (avmm_byteenable),
      .i_ridx  (w_idx),
      .o_rdata (w_rd),
      .o_regs  (cfg_regs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= RSP_IDLE;
         r_cnt           <= '0;
         r_readdata      <= '0;
         r_readdatavalid <= 1'b0;
         r_wr_strobe     <= 1'b0;
         r_wr_index      <= '0;
         r_err_sticky    <= 1'b0;
      end else begin
         r_readdatavalid <= 1'b0;
         r_wr_strobe     <= 1'b0;
         if (clr_err) r_err_sticky <= 1'b0;
         case (r_state)
            RSP_IDLE: begin
               if (w_cmd) begin
                  if (WAIT_CYCLES == 0) begin
                     r_state <= RSP_ACK;
                  end else begin
                     r_state <= RSP_WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            RSP_WAIT: begin
               if (!w_cmd) begin
                  r_state <= RSP_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= RSP_ACK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RSP_ACK: begin
               r_state <= RSP_IDLE;
               if (avmm_write) begin
                  if (w_in_range) begin
                     r_wr_strobe <= 1'b1;
                     r_wr_index  <= w_idx;
                  end
               end else if (avmm_read) begin
                  r_readdatavalid <= 1'b1;
                  r_readdata      <= w_in_range ? w_rd : BAD_RDATA;
               end
               // Placed after the clear so a same-cycle error wins.
               if (w_err) r_err_sticky <= 1'b1;
            end
            default: r_state <= RSP_IDLE;
         endcase
      end
   end

   assign avmm_readdata      = r_readdata;
   assign avmm_readdatavalid = r_readdatavalid;
   assign wr_strobe          = r_wr_strobe;
   assign wr_index           = r_wr_index;
   assign err_sticky         = r_err_sticky;

endmodule

// File: tb/tb_avmm_cfg_responder.sv
// Directed, table-driven bench for avmm_cfg_responder (WAIT_CYCLES=2 and 0 instances).
module tb_avmm_cfg_responder;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [16:0]   a_addr = '0;
   logic [31:0]   a_wdata = '0;
   logic [3:0]    a_be = '0;
   logic          a_wr = 1'b0;
   logic          a_rd = 1'b0;
   logic          a_clr = 1'b0;
   logic          a_wait;
   logic [31:0]   a_rdata;
   logic          a_rdv;
   logic [1023:0] a_regs;
   logic          a_stb;
   logic [4:0]    a_idx;
   logic          a_err;

   logic [16:0]   b_addr = '0;
   logic [31:0]   b_wdata = '0;
   logic [3:0]    b_be = '0;
   logic          b_wr = 1'b0;
   logic          b_rd = 1'b0;
   logic          b_clr = 1'b0;
   logic          b_wait;
   logic [31:0]   b_rdata;
   logic          b_rdv;
   logic [1023:0] b_regs;
   logic          b_stb;
   logic [4:0]    b_idx;
   logic          b_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   avmm_cfg_responder #(
      .BASE_ADDR   (17'h00200),
      .NUM_REGS    (32),
      .WAIT_CYCLES (2),
      .BAD_RDATA   (32'hDEAD_BEEF)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .avmm_address       (a_addr),
      .avmm_writedata     (a_wdata),
      .avmm_byteenable    (a_be),
      .avmm_write         (a_wr),
      .avmm_read          (a_rd),
      .avmm_waitrequest   (a_wait),
      .avmm_readdata      (a_rdata),
      .avmm_readdatavalid (a_rdv),
      .cfg_regs           (a_regs),
      .wr_strobe          (a_stb),
      .wr_index           (a_idx),
      .clr_err            (a_clr),
      .err_sticky         (a_err)
   );

   avmm_cfg_responder #(
      .BASE_ADDR   (17'h00200),
      .NUM_REGS    (32),
      .WAIT_CYCLES (0),
      .BAD_RDATA   (32'hDEAD_BEEF)
   ) dut0 (
      .clk                (clk),
      .rst                (rst),
      .avmm_address       (b_addr),
      .avmm_writedata     (b_wdata),
      .avmm_byteenable    (b_be),
      .avmm_write         (b_wr),
      .avmm_read          (b_rd),
      .avmm_waitrequest   (b_wait),
      .avmm_readdata      (b_rdata),
      .avmm_readdatavalid (b_rdv),
      .cfg_regs           (b_regs),
      .wr_strobe          (b_stb),
      .wr_index           (b_idx),
      .clr_err            (b_clr),
      .err_sticky         (b_err)
   );

   // clr: 0 = none, 1 = pulse before the access, 2 = held high throughout it
   typedef struct {
      logic [1:0]  clr;
      logic        wr;
      logic        rd;
      logic [16:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        rdv;
      logic [31:0] rdata;
      logic        stb;
      logic [4:0]  idx;
      logic        err;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic access(input bit sel, input logic w, input logic r,
                         input logic [16:0] a, input logic [31:0] d, input logic [3:0] be,
                         output int hi, output logic rdv, output logic [31:0] rd,
                         output logic stb, output logic [4:0] idx, output logic err);
      @(negedge clk);
      if (sel) begin
         b_addr = a; b_wdata = d; b_be = be; b_wr = w; b_rd = r;
      end else begin
         a_addr = a; a_wdata = d; a_be = be; a_wr = w; a_rd = r;
      end
      #1;
      hi = 0;
      while ((sel ? b_wait : a_wait) && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      @(negedge clk);
      rdv = sel ? b_rdv : a_rdv;
      rd  = sel ? b_rdata : a_rdata;
      stb = sel ? b_stb : a_stb;
      idx = sel ? b_idx : a_idx;
      err = sel ? b_err : a_err;
      if (sel) begin
         b_wr = 1'b0; b_rd = 1'b0;
      end else begin
         a_wr = 1'b0; a_rd = 1'b0;
      end
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int          hi;
      logic        rdv, stb, err, seen;
      logic [31:0] rd;
      logic [4:0]  idx;

      vecs[0]  = '{2'd0, N, Y, 17'h00200, 32'h0,         4'hF, Y, 32'h0000_0000, N, 5'd0,  N};
      vecs[1]  = '{2'd0, Y, N, 17'h00204, 32'h1122_3344, 4'hF, N, 32'h0,         Y, 5'd1,  N};
      vecs[2]  = '{2'd0, Y, N, 17'h00204, 32'hAABB_CCDD, 4'h5, N, 32'h0,         Y, 5'd1,  N};
      vecs[3]  = '{2'd0, N, Y, 17'h00204, 32'h0,         4'hF, Y, 32'h11BB_33DD, N, 5'd0,  N};
      vecs[4]  = '{2'd0, N, Y, 17'h00300, 32'h0,         4'hF, Y, 32'hDEAD_BEEF, N, 5'd0,  Y};
      vecs[5]  = '{2'd1, N, Y, 17'h00200, 32'h0,         4'hF, Y, 32'h0000_0000, N, 5'd0,  N};
      vecs[6]  = '{2'd0, Y, Y, 17'h00208, 32'h0000_0005, 4'hF, N, 32'h0,         Y, 5'd2,  Y};
      vecs[7]  = '{2'd1, N, Y, 17'h00208, 32'h0,         4'hF, Y, 32'h0000_0005, N, 5'd0,  N};
      vecs[8]  = '{2'd0, Y, N, 17'h00280, 32'h0000_0077, 4'hF, N, 32'h0,         N, 5'd0,  Y};
      vecs[9]  = '{2'd1, N, Y, 17'h0020A, 32'h0,         4'hF, Y, 32'hDEAD_BEEF, N, 5'd0,  Y};
      vecs[10] = '{2'd1, Y, N, 17'h0027C, 32'hCAFE_F00D, 4'hF, N, 32'h0,         Y, 5'd31, N};
      vecs[11] = '{2'd0, N, Y, 17'h0027C, 32'h0,         4'hF, Y, 32'hCAFE_F00D, N, 5'd0,  N};
      vecs[12] = '{2'd2, N, Y, 17'h001FC, 32'h0,         4'hF, Y, 32'hDEAD_BEEF, N, 5'd0,  Y};
      vecs[13] = '{2'd1, Y, N, 17'h00204, 32'hFFFF_FFFF, 4'h0, N, 32'h0,         Y, 5'd1,  N};
      vecs[14] = '{2'd0, N, Y, 17'h00204, 32'h0,         4'hF, Y, 32'h11BB_33DD, N, 5'd0,  N};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_readdata", a_rdata, 32'h0);
      chk("rst_rdv", 32'(a_rdv), 32'h0);
      chk("rst_strobe", 32'(a_stb), 32'h0);
      chk("rst_index", 32'(a_idx), 32'h0);
      chk("rst_err", 32'(a_err), 32'h0);
      chk("rst_wait", 32'(a_wait), 32'h0);
      chk("rst_regs_nonzero", 32'(a_regs != '0), 32'h0);

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].clr == 2'd1) begin
            @(negedge clk); a_clr = 1'b1;
            @(negedge clk); a_clr = 1'b0;
         end else if (vecs[i].clr == 2'd2) begin
            a_clr = 1'b1;
         end
         access(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                hi, rdv, rd, stb, idx, err);
         a_clr = 1'b0;
         chk($sformatf("v%0d_wait_cycles", i), 32'(hi), 32'd3);
         chk($sformatf("v%0d_rdv", i), 32'(rdv), 32'(vecs[i].rdv));
         if (vecs[i].rdv) chk($sformatf("v%0d_readdata", i), rd, vecs[i].rdata);
         chk($sformatf("v%0d_strobe", i), 32'(stb), 32'(vecs[i].stb));
         if (vecs[i].stb) chk($sformatf("v%0d_index", i), 32'(idx), 32'(vecs[i].idx));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
         @(negedge clk);
         chk($sformatf("v%0d_pulse_end", i), 32'(a_rdv | a_stb), 32'h0);
      end

      chk("cfg_reg0", a_regs[31:0], 32'h0);
      chk("cfg_reg1", a_regs[63:32], 32'h11BB_33DD);
      chk("cfg_reg2", a_regs[95:64], 32'h0000_0005);
      chk("cfg_reg31", a_regs[1023:992], 32'hCAFE_F00D);

      // Master drops the read during WAIT: no completion, no error.
      @(negedge clk); a_rd = 1'b1; a_addr = 17'h00200;
      @(negedge clk); a_rd = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (a_rdv || a_wait) seen = 1'b1;
      end
      chk("abort_no_rdv", 32'(seen), 32'h0);
      chk("abort_no_err", 32'(a_err), 32'h0);

      // Reset during WAIT of a write to reg3.
      @(negedge clk);
      a_wr = 1'b1; a_addr = 17'h0020C; a_wdata = 32'h1234_5678; a_be = 4'hF;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; a_wr = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (a_stb) seen = 1'b1;
      end
      chk("rstwait_no_strobe", 32'(seen), 32'h0);
      chk("rstwait_reg3", a_regs[127:96], 32'h0);
      chk("rstwait_reg1_cleared", a_regs[63:32], 32'h0);
      chk("rstwait_readdata", a_rdata, 32'h0);
      access(1'b0, 1'b0, 1'b1, 17'h0020C, 32'h0, 4'hF, hi, rdv, rd, stb, idx, err);
      chk("rstwait_rd_wait", 32'(hi), 32'd3);
      chk("rstwait_rd_rdv", 32'(rdv), 32'h1);
      chk("rstwait_rd_data", rd, 32'h0);

      // WAIT_CYCLES = 0: four back-to-back writes, two cycles each.
      @(negedge clk);
      b_wr = 1'b1; b_be = 4'hF; b_addr = 17'h00200; b_wdata = 32'h1111_0000;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("b2b%0d_wait_hi", k), 32'(b_wait), 32'h1);
         @(negedge clk);
         chk($sformatf("b2b%0d_wait_lo", k), 32'(b_wait), 32'h0);
         @(negedge clk);
         chk($sformatf("b2b%0d_strobe", k), 32'(b_stb), 32'h1);
         chk($sformatf("b2b%0d_index", k), 32'(b_idx), 32'(k));
         if (k < 3) begin
            b_addr  = 17'h00200 + 17'(4 * (k + 1));
            b_wdata = 32'h1111_0000 + 32'(k + 1);
         end else begin
            b_wr = 1'b0;
         end
      end
      for (int k = 0; k < 4; k++) begin
         access(1'b1, 1'b0, 1'b1, 17'h00200 + 17'(4 * k), 32'h0, 4'hF, hi, rdv, rd, stb, idx, err);
         chk($sformatf("b2b_rd%0d_wait", k), 32'(hi), 32'd1);
         chk($sformatf("b2b_rd%0d_data", k), rd, 32'h1111_0000 + 32'(k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
